// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch definitions: opcode encodings, NZP bit positions,
// the fetch FSM state type and the PCoffset9 sign-extension helper.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_JMP = 4'b1100;

   localparam int NZP_N = 2;
   localparam int NZP_Z = 1;
   localparam int NZP_P = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } fetch_state_e;

   function automatic logic [15:0] sext9(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction

endpackage

// File: rtl/lc3_next_pc.sv
// Combinational next-PC selection: branch target, register jump or fall-through,
// plus the incremented value that becomes the architectural PC.
module lc3_next_pc
   import lc3_pkg::*;
(
   input  logic [15:0] pc_i,
   input  logic [3:0]  opcode_i,
   input  logic [8:0]  offset_i,
   input  logic [15:0] reg_i,
   input  logic [2:0]  br_nzp_i,
   input  logic [2:0]  result_nzp_i,
   output logic [15:0] target_o,
   output logic [15:0] target_plus1_o
);

   logic br_taken;

   // An all-zero mask can never match, so BR with nzp=000 always falls through.
   assign br_taken = (br_nzp_i[NZP_N] & result_nzp_i[NZP_N]) |
                     (br_nzp_i[NZP_Z] & result_nzp_i[NZP_Z]) |
                     (br_nzp_i[NZP_P] & result_nzp_i[NZP_P]);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      target_o = pc_i;
      case (opcode_i)
         OP_BR:          if (br_taken) target_o = pc_i + sext9(offset_i);
         OP_JMP, OP_JSR: target_o = reg_i;
         default:        target_o = pc_i;
      endcase
   end

   // 16-bit adders wrap naturally modulo 2^16.
   assign target_plus1_o = target_o + 16'h0001;

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch: a two-state IDLE/ISSUE FSM that, on each accepted
// fetch request, issues the target address and advances the architectural PC.
module lc3_fetch
   import lc3_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic [3:0]  opcode_in,
   input  logic [8:0]  offset_in,
   input  logic [15:0] reg_in,
   input  logic [2:0]  br_nzp,
   input  logic [2:0]  result_nzp,
   output logic [15:0] addr_out,
   output logic        wea_out,
   output logic [15:0] pc
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  addr_q, addr_d;
   logic         wea_q;
   logic [15:0]  target;
   logic [15:0]  target_plus1;

   lc3_next_pc u_next_pc (
      .pc_i           (pc_q),
      .opcode_i       (opcode_in),
      .offset_i       (offset_in),
      .reg_i          (reg_in),
      .br_nzp_i       (br_nzp),
      .result_nzp_i   (result_nzp),
      .target_o       (target),
      .target_plus1_o (target_plus1)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_start) begin
               state_d = ST_ISSUE;
               addr_d  = target;
               pc_d    = target_plus1;
            end
         end
         ST_ISSUE: state_d = ST_IDLE;   // a request arriving here is dropped
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= 16'h0000;
         wea_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         wea_q   <= 1'b0;
      end
   end

   assign addr_out = addr_q;
   assign wea_out  = wea_q;
   assign pc       = pc_q;

endmodule

// File: tb/tb_lc3_fetch.sv
// Self-checking bench for lc3_fetch: a vector table applied through a
// scoreboard queue, plus directed reset, ISSUE-ignore and wrap sequences.
module tb_lc3_fetch;
   import lc3_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic [3:0]  opcode_in;
   logic [8:0]  offset_in;
   logic [15:0] reg_in;
   logic [2:0]  br_nzp;
   logic [2:0]  result_nzp;
   logic [15:0] addr_out;
   logic        wea_out;
   logic [15:0] pc;

   always #5 clk = ~clk;

   lc3_fetch #(.RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .opcode_in   (opcode_in),
      .offset_in   (offset_in),
      .reg_in      (reg_in),
      .br_nzp      (br_nzp),
      .result_nzp  (result_nzp),
      .addr_out    (addr_out),
      .wea_out     (wea_out),
      .pc          (pc)
   );

   typedef struct {
      logic [3:0]  op;
      logic [8:0]  off;
      logic [15:0] rg;
      logic [2:0]  br;
      logic [2:0]  res;
      logic [15:0] exp_addr;
      logic [15:0] exp_pc;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] pc;
   } exp_t;

   vec_t vecs[15];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [8:0] off, input logic [15:0] rg,
                        input logic [2:0] br, input logic [2:0] res);
      opcode_in  = op;
      offset_in  = off;
      reg_in     = rg;
      br_nzp     = br;
      result_nzp = res;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " addr"}, addr_out, e.addr);
         check({tag, " pc"}, pc, e.pc);
         check({tag, " wea"}, {15'd0, wea_out}, 16'h0000);
      end
   endtask

   task automatic do_fetch(input int i);
      exp_t e;
      @(negedge clk);
      drive(vecs[i].op, vecs[i].off, vecs[i].rg, vecs[i].br, vecs[i].res);
      fetch_start = 1'b1;
      e.addr = vecs[i].exp_addr;
      e.pc   = vecs[i].exp_pc;
      sb.push_back(e);
      @(posedge clk);
      #1 fetch_start = 1'b0;
      pop_check($sformatf("vec%0d", i));
      @(posedge clk);   // ISSUE -> IDLE, outputs must hold
      #1 check($sformatf("vec%0d hold pc", i), pc, vecs[i].exp_pc);
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [8:0] off, input logic [15:0] rg,
                               input logic [2:0] br, input logic [2:0] res,
                               input logic [15:0] ea, input logic [15:0] ep);
      vec_t v;
      v.op = op; v.off = off; v.rg = rg; v.br = br; v.res = res;
      v.exp_addr = ea; v.exp_pc = ep;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0000, 16'h0001);
      vecs[1]  = mk(4'b0001, 9'h0FF, 16'hABCD, 3'b111, 3'b111, 16'h0001, 16'h0002);
      vecs[2]  = mk(4'b1100, 9'h1FE, 16'h000F, 3'b111, 3'b111, 16'h000F, 16'h0010);
      vecs[3]  = mk(4'b0000, 9'h1FE, 16'h9999, 3'b110, 3'b010, 16'h000E, 16'h000F);
      vecs[4]  = mk(4'b1100, 9'h000, 16'h000F, 3'b000, 3'b000, 16'h000F, 16'h0010);
      vecs[5]  = mk(4'b0000, 9'h1FE, 16'h9999, 3'b110, 3'b001, 16'h0010, 16'h0011);
      vecs[6]  = mk(4'b1100, 9'h0FF, 16'h3000, 3'b111, 3'b111, 16'h3000, 16'h3001);
      vecs[7]  = mk(4'b0100, 9'h0FF, 16'h1234, 3'b111, 3'b111, 16'h1234, 16'h1235);
      vecs[8]  = mk(4'b0000, 9'h0FF, 16'h0000, 3'b000, 3'b111, 16'h1235, 16'h1236);
      vecs[9]  = mk(4'b0000, 9'h0FF, 16'h0000, 3'b111, 3'b100, 16'h1335, 16'h1336);
      vecs[10] = mk(4'b1111, 9'h0FF, 16'h5555, 3'b111, 3'b111, 16'h1336, 16'h1337);
      vecs[11] = mk(4'b1100, 9'h000, 16'hFFFE, 3'b000, 3'b000, 16'hFFFE, 16'hFFFF);
      vecs[12] = mk(4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'hFFFF, 16'h0000);
      vecs[13] = mk(4'b1100, 9'h000, 16'hFFFE, 3'b000, 3'b000, 16'hFFFE, 16'hFFFF);
      vecs[14] = mk(4'b0000, 9'h001, 16'h0000, 3'b001, 3'b001, 16'h0000, 16'h0001);

      // Reset held for five cycles, then idle with fetch_start low.
      rst = 1'b1;
      fetch_start = 1'b0;
      drive(4'b0000, 9'h000, 16'h0000, 3'b000, 3'b000);
      repeat (5) @(posedge clk);
      #1 check("reset addr", addr_out, 16'h0000);
      check("reset pc", pc, 16'h0000);
      check("reset wea", {15'd0, wea_out}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      drive(4'b1100, 9'h0FF, 16'h1234, 3'b111, 3'b111);
      repeat (4) @(posedge clk);
      #1 check("idle addr", addr_out, 16'h0000);
      check("idle pc", pc, 16'h0000);
      check("idle wea", {15'd0, wea_out}, 16'h0000);

      for (int i = 0; i < 15; i++) do_fetch(i);

      // Reset asserted while in ISSUE.
      @(negedge clk);
      drive(4'b1100, 9'h000, 16'h3000, 3'b000, 3'b000);
      fetch_start = 1'b1;
      @(posedge clk);
      #1 fetch_start = 1'b0;
      check("pre-rst addr", addr_out, 16'h3000);
      check("pre-rst pc", pc, 16'h3001);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst-issue addr", addr_out, 16'h0000);
      check("rst-issue pc", pc, 16'h0000);
      check("rst-issue wea", {15'd0, wea_out}, 16'h0000);

      // fetch_start held high across IDLE, ISSUE, IDLE: the ISSUE edge must be ignored.
      @(negedge clk);
      drive(4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
      fetch_start = 1'b1;
      @(posedge clk);
      #1 check("hold1 addr", addr_out, 16'h0000);
      check("hold1 pc", pc, 16'h0001);
      @(posedge clk);
      #1 check("issue-ign addr", addr_out, 16'h0000);
      check("issue-ign pc", pc, 16'h0001);
      @(posedge clk);
      #1 fetch_start = 1'b0;
      check("hold3 addr", addr_out, 16'h0001);
      check("hold3 pc", pc, 16'h0002);
      @(posedge clk);

      // Reset wins over a simultaneous fetch request in IDLE.
      @(negedge clk);
      drive(4'b1100, 9'h000, 16'h4444, 3'b000, 3'b000);
      rst = 1'b1;
      fetch_start = 1'b1;
      @(posedge clk);
      #1 check("rst-prio addr", addr_out, 16'h0000);
      check("rst-prio pc", pc, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      fetch_start = 1'b0;
      @(posedge clk);
      #1 check("post-rst addr", addr_out, 16'h0000);
      check("post-rst pc", pc, 16'h0000);

      // Negative offset wrapping below zero: 0 + (-1) = FFFF.
      @(negedge clk);
      drive(4'b0000, 9'h1FF, 16'h0000, 3'b111, 3'b010);
      fetch_start = 1'b1;
      @(posedge clk);
      #1 fetch_start = 1'b0;
      check("negwrap addr", addr_out, 16'hFFFF);
      check("negwrap pc", pc, 16'h0000);
      @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lc3_fetch.md
LC3_FETCH -- requirements
Module: lc3_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk, input, 1 bit, rising-edge clock for all state.
REQ-003 rst, input, 1 bit, synchronous active-high reset.
REQ-004 fetch_start, input, 1 bit, single-cycle request to fetch the next instruction.
REQ-005 opcode_in, input, 4 bits, opcode of the instruction just completed.
REQ-006 offset_in, input, 9 bits, PCoffset9 field of that instruction.
REQ-007 reg_in, input, 16 bits, base-register value for JMP/RET/JSRR.
REQ-008 br_nzp, input, 3 bits, n/z/p mask from the BR instruction.
REQ-009 result_nzp, input, 3 bits, current condition codes, {N,Z,P}.
REQ-010 addr_out, output, 16 bits, instruction-memory address.
REQ-011 wea_out, output, 1 bit, memory write enable.
REQ-012 pc, output, 16 bits, architectural PC, which is the address of the next sequential instruction.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and ISSUE, with all outputs registered.
REQ-014 IDLE with fetch_start=1 SHALL go to ISSUE on the next edge; IDLE with fetch_start=0 SHALL hold all outputs.
REQ-015 ISSUE SHALL return to IDLE after exactly one cycle; fetch_start asserted in ISSUE SHALL be ignored.
REQ-016 On the IDLE-to-ISSUE edge, the block SHALL compute target and SHALL load addr_out <= target and pc <= target + 1 (latency 1 cycle).
REQ-017 BR (opcode 0000) target SHALL be pc + sign_extend(offset_in) when (br_nzp & result_nzp) != 0, else pc.
REQ-018 JMP/RET (opcode 1100) and JSR/JSRR (opcode 0100) target SHALL be reg_in.
REQ-019 All other opcodes SHALL use target = pc.
REQ-020 Arithmetic SHALL be 16-bit modulo 2^16: 16'hFFFF + 1 = 16'h0000, and negative offsets wrap below 0.
REQ-021 wea_out SHALL be constantly 0, because fetch only reads memory.
REQ-022 br_nzp = 000 SHALL never take the branch, whatever result_nzp holds.

Reset
REQ-023 While rst=1 at a rising edge, pc SHALL be set to RESET_PC, addr_out to 16'h0000, wea_out to 0, and the state to IDLE.
REQ-024 Reset SHALL take priority over fetch_start, including reset asserted while the FSM is in ISSUE.
REQ-025 After rst is released with fetch_start=0, all outputs SHALL hold their reset values indefinitely.

Structure
REQ-026 A shared package lc3_pkg SHALL hold the opcode constants (OP_BR=0000, OP_JSR=0100, OP_JMP=1100), the NZP bit positions and the fetch state enum.
REQ-027 Next-PC selection and the adder SHALL be one combinational sub-module, lc3_next_pc; the FSM and registers SHALL stay in lc3_fetch.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset and idle: hold rst 5 cycles, release, fetch_start=0 -> addr_out=0, wea_out=0, pc=0.
- Sequential fetch: opcode 0001, one fetch_start pulse from pc=0 -> addr_out=0, pc=1; a second pulse -> addr_out=1, pc=2.
- BRnz taken: pc=16'h0010, br_nzp=110, result_nzp=010, offset=9'h1FE (-2) -> addr_out=16'h000E, pc=16'h000F.
- BRnz not taken: pc=16'h0010, br_nzp=110, result_nzp=001 -> addr_out=16'h0010, pc=16'h0011.
- JMP: opcode 1100, reg_in=16'h3000 -> addr_out=16'h3000, pc=16'h3001.
- Wrap and reset mid-ISSUE: pc=16'hFFFF, BR taken with offset +1 -> addr_out=16'h0000, pc=16'h0001; rst asserted in ISSUE -> all outputs 0 on the next edge.
